// File: rtl/lvt_ram_mrnw.sv
// Multi-read / multi-write RAM built from NW x NR replicated banks and a live
// value table (LVT) that records which write port last wrote each address.
// Same-address write collisions keep the lowest-index port and flag the rest.
// After reset a sweep clears the LVT and bank 0 so the whole array reads as 0.
module lvt_ram_mrnw #(
    parameter int NR = 8,
    parameter int NW = 8,
    parameter int DW = 32,
    parameter int AW = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    w_en,
    input  logic [NW*AW-1:0] w_addr,
    input  logic [NW*DW-1:0] w_din,
    input  logic [NR*AW-1:0] r_addr,
    output logic [NR*DW-1:0] r_dout,
    output logic             ready,
    output logic [NW-1:0]    w_conflict
);
    localparam int DEPTH = 1 << AW;
    localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_addr;
    logic [NW-1:0]   accept;
    logic [NW-1:0]   drop;
    logic            wr_ok;
    logic            clr_ok;

    logic [LW-1:0]   lvt  [DEPTH];
    logic [DW-1:0]   bank [NW][NR][DEPTH];

    // Writes and clears are suppressed on any edge where rst is high
    assign wr_ok  = (state == READY) && !rst;
    assign clr_ok = (state == CLEAR) && !rst;
    assign ready  = (state == READY);

    // Collision resolution: a port is dropped if any lower-index enabled port shares its address
    always_comb begin
        accept = '0;
        drop   = '0;
        for (int i = 0; i < NW; i++) begin
            if (w_en[i]) begin
                for (int k = 0; k < NW; k++) begin
                    if (k < i && w_en[k] && (w_addr[k*AW +: AW] == w_addr[i*AW +: AW])) begin
                        drop[i] = 1'b1;
                    end
                end
                accept[i] = !drop[i];
            end
        end
    end

    // FSM state register and clear-sweep address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + AW'(1);
            end
        end
    end

    // Next state: leave CLEAR on the edge that clears the last address
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_addr == {AW{1'b1}}) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // Per-port conflict flag, registered; never asserted during the sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            w_conflict <= '0;
        end else if (state == READY) begin
            w_conflict <= drop;
        end else begin
            w_conflict <= '0;
        end
    end

    // LVT update: sweep clears entries to port 0, accepted writes record their port index
    always_ff @(posedge clk) begin
        if (clr_ok) begin
            lvt[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NW; i++) begin
                if (accept[i]) begin
                    lvt[w_addr[i*AW +: AW]] <= LW'(i);
                end
            end
        end
    end

    // Bank update: sweep zeroes bank 0, accepted write i fills its row of NR replicas
    always_ff @(posedge clk) begin
        if (clr_ok) begin
            for (int j = 0; j < NR; j++) begin
                bank[0][j][clr_addr] <= '0;
            end
        end else if (wr_ok) begin
            for (int i = 0; i < NW; i++) begin
                if (accept[i]) begin
                    for (int j = 0; j < NR; j++) begin
                        bank[i][j][w_addr[i*AW +: AW]] <= w_din[i*DW +: DW];
                    end
                end
            end
        end
    end

    // Registered read, read-first: the bank selected by the pre-write LVT entry
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            r_dout <= '0;
        end else begin
            for (int j = 0; j < NR; j++) begin
                r_dout[j*DW +: DW] <= bank[lvt[r_addr[j*AW +: AW]]][j][r_addr[j*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_lvt_ram_mrnw.sv
// Directed bench for lvt_ram_mrnw: a small AW=4 instance for the clear sweep
// and a default-sized instance for parallel writes, collisions, read-first,
// overwrite tracking and mid-operation reset.
module tb_lvt_ram_mrnw;
    localparam int NR  = 8;
    localparam int NW  = 8;
    localparam int DW  = 32;
    localparam int AWA = 4;
    localparam int AWB = 11;

    logic clk = 1'b0;
    logic rst;

    logic [NW-1:0]      a_w_en, b_w_en;
    logic [NW*AWA-1:0]  a_w_addr;
    logic [NW*AWB-1:0]  b_w_addr;
    logic [NW*DW-1:0]   a_w_din, b_w_din;
    logic [NR*AWA-1:0]  a_r_addr;
    logic [NR*AWB-1:0]  b_r_addr;
    logic [NR*DW-1:0]   a_r_dout, b_r_dout;
    logic               a_ready, b_ready;
    logic [NW-1:0]      a_w_conflict, b_w_conflict;

    int errors = 0;
    int checks = 0;

    lvt_ram_mrnw #(.NR(NR), .NW(NW), .DW(DW), .AW(AWA)) dut_a (
        .clk(clk), .rst(rst), .w_en(a_w_en), .w_addr(a_w_addr), .w_din(a_w_din),
        .r_addr(a_r_addr), .r_dout(a_r_dout), .ready(a_ready), .w_conflict(a_w_conflict)
    );

    lvt_ram_mrnw #(.NR(NR), .NW(NW), .DW(DW), .AW(AWB)) dut_b (
        .clk(clk), .rst(rst), .w_en(b_w_en), .w_addr(b_w_addr), .w_din(b_w_din),
        .r_addr(b_r_addr), .r_dout(b_r_dout), .ready(b_ready), .w_conflict(b_w_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bw(input int p, input logic [AWB-1:0] ad, input logic [DW-1:0] d);
        b_w_en[p]             = 1'b1;
        b_w_addr[p*AWB +: AWB] = ad;
        b_w_din[p*DW +: DW]    = d;
    endtask

    task automatic b_read_all(input logic [AWB-1:0] ad);
        for (int j = 0; j < NR; j++) b_r_addr[j*AWB +: AWB] = ad;
    endtask

    task automatic wait_b_ready(input string tag, output int n);
        n = 0;
        while (!b_ready && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 256'(b_ready), 256'(1));
    endtask

    initial begin
        int n;
        logic [NR*DW-1:0] exp_v;

        rst = 1'b1;
        a_w_en = '0; a_w_addr = '0; a_w_din = '0; a_r_addr = '0;
        b_w_en = '0; b_w_addr = '0; b_w_din = '0; b_r_addr = '0;
        tick();
        tick();
        check("rst_a_ready", 256'(a_ready), 256'(0));
        check("rst_a_dout", 256'(a_r_dout), 256'(0));
        check("rst_a_conflict", 256'(a_w_conflict), 256'(0));
        check("rst_b_ready", 256'(b_ready), 256'(0));

        // Sweep on the AW=4 instance, with colliding writes injected mid-sweep
        rst = 1'b0;
        n = 0;
        while (!a_ready && n < 100) begin
            if (n == 5) begin
                a_w_en = 8'b0001_1000;
                a_w_addr[3*AWA +: AWA] = 4'd1;
                a_w_addr[4*AWA +: AWA] = 4'd1;
                a_w_din[3*DW +: DW] = 32'hDEAD;
                a_w_din[4*DW +: DW] = 32'hBEEF;
            end else begin
                a_w_en = '0;
            end
            if (n == 6) begin
                check("sweep_conflict", 256'(a_w_conflict), 256'(0));
                check("sweep_dout", 256'(a_r_dout), 256'(0));
            end
            tick();
            n++;
        end
        a_w_en = '0;
        check("a_ready_latency", 256'(n), 256'(16));
        for (int ad = 0; ad < 16; ad++) begin
            for (int j = 0; j < NR; j++) a_r_addr[j*AWA +: AWA] = AWA'(ad);
            tick();
            check($sformatf("a_clear_rd_%0d", ad), 256'(a_r_dout), 256'(0));
        end

        // Default instance: eight parallel writes to distinct addresses
        wait_b_ready("b_ready_first", n);
        for (int i = 0; i < NW; i++) bw(i, AWB'(8*i), DW'(32'hA0 + i));
        tick();
        b_w_en = '0;
        check("par_conflict", 256'(b_w_conflict), 256'(0));
        for (int j = 0; j < NR; j++) b_r_addr[j*AWB +: AWB] = AWB'(8*j);
        tick();
        for (int j = 0; j < NR; j++)
            check($sformatf("par_rd_%0d", j), 256'(b_r_dout[j*DW +: DW]), 256'(32'hA0 + j));

        // Three-way collision on 0x3FF: port 2 wins, 5 and 7 flagged
        bw(2, 11'h3FF, 32'h11);
        bw(5, 11'h3FF, 32'h55);
        bw(7, 11'h3FF, 32'h77);
        tick();
        b_w_en = '0;
        check("coll_conflict", 256'(b_w_conflict), 256'(8'hA0));
        b_read_all(11'h3FF);
        tick();
        check("coll_conflict_clr", 256'(b_w_conflict), 256'(0));
        for (int j = 0; j < NR; j++) exp_v[j*DW +: DW] = 32'h11;
        check("coll_rd", 256'(b_r_dout), 256'(exp_v));

        // Read-first on address 5
        bw(0, 11'd5, 32'h1234);
        tick();
        b_w_en = '0;
        bw(3, 11'd5, 32'hBEEF);
        b_r_addr[6*AWB +: AWB] = 11'd5;
        tick();
        b_w_en = '0;
        check("rf_old", 256'(b_r_dout[6*DW +: DW]), 256'(32'h1234));
        tick();
        check("rf_new", 256'(b_r_dout[6*DW +: DW]), 256'(32'hBEEF));

        // Overwrite tracking on address 9 across two ports
        bw(1, 11'd9, 32'h1);
        tick();
        b_w_en = '0;
        bw(4, 11'd9, 32'h4);
        tick();
        b_w_en = '0;
        b_read_all(11'd9);
        tick();
        for (int j = 0; j < NR; j++) exp_v[j*DW +: DW] = 32'h4;
        check("ovw_rd", 256'(b_r_dout), 256'(exp_v));

        // Reset mid-operation, with a write presented on the reset edge
        rst = 1'b1;
        bw(0, 11'd100, 32'h99);
        tick();
        b_w_en = '0;
        check("mid_rst_dout", 256'(b_r_dout), 256'(0));
        check("mid_rst_ready", 256'(b_ready), 256'(0));
        rst = 1'b0;
        wait_b_ready("b_ready_second", n);
        check("b_ready_latency", 256'(n), 256'(2048));
        b_read_all(11'h3FF);
        tick();
        check("post_rst_3ff", 256'(b_r_dout), 256'(0));
        b_read_all(11'd5);
        tick();
        check("post_rst_5", 256'(b_r_dout), 256'(0));
        b_read_all(11'd9);
        tick();
        check("post_rst_9", 256'(b_r_dout), 256'(0));
        for (int j = 0; j < NR; j++) b_r_addr[j*AWB +: AWB] = AWB'(8*j);
        tick();
        check("post_rst_par", 256'(b_r_dout), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lvt_ram_mrnw.md
LVT_RAM_MRNW -- requirements
Module: lvt_ram_mrnw

Interface
REQ-001 SHALL have parameter NR, default 8: number of read ports (1..16).
REQ-002 SHALL have parameter NW, default 8: number of write ports (2..16).
REQ-003 SHALL have parameter DW, default 32: data width in bits.
REQ-004 SHALL have parameter AW, default 11: address width in bits; depth is 2^AW words.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL provide port w_en, input, NW bits: bit i is the write enable for write port i.
REQ-009 SHALL provide port w_addr, input, NW*AW bits: slice [i*AW +: AW] is the address for write port i.
REQ-010 SHALL provide port w_din, input, NW*DW bits: slice [i*DW +: DW] is the write data for write port i.
REQ-011 SHALL provide port r_addr, input, NR*AW bits: slice [j*AW +: AW] is the address for read port j.
REQ-012 SHALL provide port r_dout, output, NR*DW bits: slice [j*DW +: DW] is the registered read data for read port j.
REQ-013 SHALL provide port ready, output, 1 bit: high once the post-reset clear sweep has completed.
REQ-014 SHALL provide port w_conflict, output, NW bits: registered flag, one bit per write port, marking that port as dropped on a same-address collision.

Function
REQ-015 SHALL implement storage as NW x NR banks of 2^AW x DW; bank(i,j) is written only by write port i and read only by read port j.
REQ-016 SHALL keep a live value table (LVT) of 2^AW entries, each clog2(NW) bits wide, recording which write port last wrote each address.
REQ-017 SHALL, on an accepted write on port i, write w_din slice i into bank(i,0..NR-1) at the given address and set LVT[addr] = i in the same edge.
REQ-018 SHALL produce r_dout[j] one cycle after r_addr[j] is presented, taken from bank(LVT[addr], j); read latency is exactly 1 cycle for every port.
REQ-019 SHALL be read-first: a read and an accepted write to the same address in the same cycle returns the pre-write value; the new value is visible one cycle later.
REQ-020 SHALL resolve two or more enabled write ports sharing an address in one cycle as follows: the lowest-index port wins; every higher-index colliding port is dropped; LVT and banks reflect the winner only.
REQ-021 SHALL set w_conflict[k] = 1 in the cycle after port k was dropped, and 0 otherwise; w_conflict[0] is always 0.
REQ-022 SHALL accept writes to distinct addresses on all NW ports in the same cycle without loss.
REQ-023 SHALL run a two-state FSM: CLEAR and READY.
REQ-024 SHALL, in CLEAR, sweep counter clr_addr from 0 to 2^AW-1, one address per cycle, writing LVT[clr_addr] = 0 and bank(0,*)[clr_addr] = 0.
REQ-025 SHALL transition from CLEAR to READY on the edge that clears address 2^AW-1; ready is high from the following cycle.
REQ-026 SHALL ignore w_en while in CLEAR: no bank or LVT update and no w_conflict assertion.
REQ-027 SHALL hold r_dout = 0 while in CLEAR.
REQ-028 SHALL remain in READY until rst is asserted.
REQ-029 SHALL wrap r_addr and w_addr naturally within AW bits; out-of-range values cannot occur.

Reset
REQ-030 SHALL, while rst = 1 at a clock edge, set the FSM to CLEAR, clr_addr to 0, ready to 0, r_dout to all zeros and w_conflict to all zeros.
REQ-031 SHALL, on rst asserted mid-operation (in either state), abort any in-flight writes and restart the full sweep from address 0 when rst falls.
REQ-032 SHALL make the whole array read as 0 after reset and the sweep; bank contents themselves are not reset beyond bank 0.

Verification
REQ-033 SHALL be verified with AW=4: deassert rst -> ready rises after exactly 16 cycles; a write attempted during the sweep is dropped, and a read of every address afterwards returns 0.
REQ-034 SHALL be verified with defaults: ports 0..7 write 0xA0+i to addresses 8*i in one cycle; next cycle all 8 read ports read 8*j -> r_dout[j] = 0xA0+j one cycle later; w_conflict = 0.
REQ-035 SHALL be verified with a collision: ports 2, 5 and 7 write 0x11, 0x55, 0x77 to address 0x3FF -> w_conflict = 0b1010_0000 for one cycle, and address 0x3FF reads 0x11.
REQ-036 SHALL be verified for read-first behaviour: address 5 holds 0x1234; same cycle, port 3 writes 0xBEEF to address 5 and read port 6 reads address 5 -> 0x1234; the re-read next cycle -> 0xBEEF.
REQ-037 SHALL be verified for overwrite tracking: port 1 writes 0x1 to address 9, then port 4 writes 0x4 to address 9 -> all read ports return 0x4.
REQ-038 SHALL be verified for reset mid-operation: assert rst in READY after writes -> r_dout = 0 and ready = 0; after the sweep, previously written addresses read 0.
